gps_acq_peak_detect: RTL and testbench

// Downstream of the acquisition correlator. Consumes one correlation result per search point
// (code phase, code NCO fraction, Doppler, match count), forms metric |count - 2^(SAMPLE_BITS-1)|,
// and tracks best and second-best peaks, with a code-phase exclusion window on the second peak.
// At search end it runs a peak/second-peak ratio test. Emits one acquisition result per search
// via a valid/ready handshake to the tracking-loop init logic.

---
 rtl/gps_acq_pkg.sv | 25 ++
 rtl/gps_acq_peak_detect_if.sv | 36 +++
 rtl/gps_acq_peak_tracker.sv | 44 ++++
 rtl/gps_acq_peak_detect.sv | 127 ++++++++++++
 tb/tb_gps_acq_peak_detect.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gps_acq_pkg.sv
// Shared types and helpers for the acquisition peak detector.
package gps_acq_pkg;
  localparam int SAMPLE_BITS = 12;
  localparam int CA_CHIPS    = 1023;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  typedef struct packed {
    logic [9:0]             phase;
    logic [4:0]             frac;
    logic signed [15:0]     doppler;
    logic [SAMPLE_BITS-1:0] metric;
  } acq_point_t;

  // Code-phase distance on the 1023-chip C/A circle.
  function automatic logic [9:0] circ_dist_1023(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] d;
    d = (a > b) ? a - b : b - a;
    if (d > 10'd511) d = 10'(CA_CHIPS) - d;
    return d;
  endfunction
endpackage

// File: rtl/gps_acq_peak_detect_if.sv
// Correlator-result input bus and acquisition-result output bus.
interface gps_acq_peak_detect_if;
  logic                                    search_start;
  logic                                    corr_complete;
  logic [9:0]                              code_phase;
  logic [4:0]                              code_nco_frac;
  logic signed [15:0]                      doppler_omega;
  logic [gps_acq_pkg::SAMPLE_BITS-1:0]     integrator;
  logic [5:0]                              sat;
  logic                                    search_complete;
  logic                                    res_ready;
  logic                                    res_valid;
  logic                                    res_detected;
  logic [9:0]                              res_code_phase;
  logic [4:0]                              res_code_frac;
  logic signed [15:0]                      res_doppler;
  logic [gps_acq_pkg::SAMPLE_BITS-1:0]     res_peak;
  logic [gps_acq_pkg::SAMPLE_BITS-1:0]     res_second;
  logic [5:0]                              res_sat;
  logic [15:0]                             res_points;
  logic                                    busy;

  modport master (
    output search_start, corr_complete, code_phase, code_nco_frac, doppler_omega,
           integrator, sat, search_complete, res_ready,
    input  res_valid, res_detected, res_code_phase, res_code_frac, res_doppler,
           res_peak, res_second, res_sat, res_points, busy
  );

  modport slave (
    input  search_start, corr_complete, code_phase, code_nco_frac, doppler_omega,
           integrator, sat, search_complete, res_ready,
    output res_valid, res_detected, res_code_phase, res_code_frac, res_doppler,
           res_peak, res_second, res_sat, res_points, busy
  );
endinterface

// File: rtl/gps_acq_peak_tracker.sv
// Best / second-best peak registers with code-phase exclusion around the best peak.
module gps_acq_peak_tracker
  import gps_acq_pkg::*;
#(
  parameter int EXCL_CHIPS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   upd,
  input  acq_point_t             pt,
  output acq_point_t             peak,
  output logic [SAMPLE_BITS-1:0] second,
  output logic                   peak_valid
);
  logic excl, beats_peak;

  always_comb begin
    excl       = peak_valid && (pt.doppler == peak.doppler) &&
                 (circ_dist_1023(pt.phase, peak.phase) <= 10'(EXCL_CHIPS));
    beats_peak = !peak_valid || (pt.metric > peak.metric);
  end

  // Strict compares: the first point seen keeps a tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak       <= '0;
      second     <= '0;
      peak_valid <= 1'b0;
    end else if (clr) begin
      peak       <= '0;
      second     <= '0;
      peak_valid <= 1'b0;
    end else if (upd) begin
      if (beats_peak) begin
        if (peak_valid && !excl) second <= peak.metric;
        peak       <= pt;
        peak_valid <= 1'b1;
      end else if ((pt.metric > second) && !excl) begin
        second <= pt.metric;
      end
    end
  end
endmodule

// File: rtl/gps_acq_peak_detect.sv
// Acquisition peak detector: folds correlator points into peak trackers, then
// applies the floor and peak/second ratio test and hands one result downstream.
module gps_acq_peak_detect
  import gps_acq_pkg::*;
#(
  parameter int EXCL_CHIPS = 2,
  parameter int THR_NUM    = 3,
  parameter int THR_DEN    = 2,
  parameter int MIN_PEAK   = 64
) (
  input logic                  clk,
  input logic                  rst,
  gps_acq_peak_detect_if.slave bus
);
  localparam int PW = SAMPLE_BITS + 8;
  localparam logic [SAMPLE_BITS-1:0] CENTRE = SAMPLE_BITS'(1 << (SAMPLE_BITS - 1));

  logic [1:0]             state;
  logic                   corr_d, done_d, corr_rise, done_rise;
  logic                   cap_vld;
  acq_point_t             cur_pt, cap_pt, peak;
  logic [SAMPLE_BITS-1:0] second;
  logic                   peak_valid;
  logic [15:0]            pt_cnt;
  logic [PW-1:0]          prod_pk, prod_sc;
  logic                   detected;

  logic                   r_valid, r_det;
  acq_point_t             r_peak;
  logic [SAMPLE_BITS-1:0] r_second;
  logic [5:0]             r_sat;
  logic [15:0]            r_points;

  assign corr_rise = bus.corr_complete & ~corr_d;
  assign done_rise = bus.search_complete & ~done_d;

  always_comb begin
    cur_pt.phase   = bus.code_phase;
    cur_pt.frac    = bus.code_nco_frac;
    cur_pt.doppler = bus.doppler_omega;
    cur_pt.metric  = (bus.integrator >= CENTRE) ? bus.integrator - CENTRE
                                                : CENTRE - bus.integrator;
  end

  gps_acq_peak_tracker #(.EXCL_CHIPS(EXCL_CHIPS)) u_trk (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.search_start),
    .upd        (cap_vld),
    .pt         (cap_pt),
    .peak       (peak),
    .second     (second),
    .peak_valid (peak_valid)
  );

  always_comb begin
    prod_pk  = PW'(peak.metric) * PW'(THR_DEN);
    prod_sc  = PW'(second) * PW'(THR_NUM);
    detected = peak_valid && (peak.metric >= SAMPLE_BITS'(MIN_PEAK)) && (prod_pk > prod_sc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      corr_d   <= 1'b0;
      done_d   <= 1'b0;
      cap_vld  <= 1'b0;
      cap_pt   <= '0;
      pt_cnt   <= '0;
      r_valid  <= 1'b0;
      r_det    <= 1'b0;
      r_peak   <= '0;
      r_second <= '0;
      r_sat    <= '0;
      r_points <= '0;
    end else begin
      corr_d  <= bus.corr_complete;
      done_d  <= bus.search_complete;
      cap_vld <= corr_rise && (state == ST_SEARCH) && !bus.search_start;
      if (corr_rise) cap_pt <= cur_pt;

      if (bus.search_start) begin
        state    <= ST_SEARCH;
        pt_cnt   <= '0;
        r_valid  <= 1'b0;
        r_det    <= 1'b0;
        r_peak   <= '0;
        r_second <= '0;
        r_sat    <= '0;
        r_points <= '0;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (corr_rise && (pt_cnt != 16'hFFFF)) pt_cnt <= pt_cnt + 16'd1;
            if (done_rise) state <= ST_DECIDE;
          end
          // Hold off while a captured point is still being folded into the trackers.
          ST_DECIDE: if (!cap_vld) begin
            state    <= ST_RESULT;
            r_valid  <= 1'b1;
            r_det    <= detected;
            r_peak   <= peak;
            r_second <= second;
            r_sat    <= bus.sat;
            r_points <= pt_cnt;
          end
          ST_RESULT: if (r_valid && bus.res_ready) begin
            r_valid <= 1'b0;
            state   <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.res_valid      = r_valid;
  assign bus.res_detected   = r_det;
  assign bus.res_code_phase = r_peak.phase;
  assign bus.res_code_frac  = r_peak.frac;
  assign bus.res_doppler    = r_peak.doppler;
  assign bus.res_peak       = r_peak.metric;
  assign bus.res_second     = r_second;
  assign bus.res_sat        = r_sat;
  assign bus.res_points     = r_points;
  assign bus.busy           = (state == ST_SEARCH) || (state == ST_DECIDE);
endmodule

// File: tb/tb_gps_acq_peak_detect.sv
// Bench for gps_acq_peak_detect: directed cases plus random searches checked
// against a point-list reference model.
module tb_gps_acq_peak_detect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gps_acq_peak_detect_if bus();

  gps_acq_peak_detect #(.EXCL_CHIPS(2), .THR_NUM(3), .THR_DEN(2), .MIN_PEAK(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int phase; int frac; int dop; int m; } pt_t;
  typedef struct { bit det; int phase; int frac; int dop; int peak; int second; int sat; int points; } res_t;

  pt_t  pts[$];
  res_t exp_r;
  bit   exp_have = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cur_sat = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int cdist(input int a, input int b);
    int d;
    d = (a > b) ? a - b : b - a;
    if (d > 511) d = 1023 - d;
    return d;
  endfunction

  // Walks the captured points in arrival order, applying the peak/second rules.
  function automatic res_t model(input pt_t q[$], input int sat);
    res_t r;
    pt_t  pk;
    bit   pv, ex;
    int   sec;
    r   = '{default: 0};
    pk  = '{default: 0};
    pv  = 1'b0;
    sec = 0;
    foreach (q[i]) begin
      ex = pv && (q[i].dop == pk.dop) && (cdist(q[i].phase, pk.phase) <= 2);
      if (!pv || q[i].m > pk.m) begin
        if (pv && !ex) sec = pk.m;
        pk = q[i];
        pv = 1'b1;
      end else if (q[i].m > sec && !ex) begin
        sec = q[i].m;
      end
    end
    r.det    = pv && (pk.m >= 64) && (pk.m * 2 > sec * 3);
    r.phase  = pk.phase;
    r.frac   = pk.frac;
    r.dop    = pk.dop;
    r.peak   = pk.m;
    r.second = sec;
    r.sat    = sat;
    r.points = (q.size() > 65535) ? 65535 : q.size();
    return r;
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst && bus.res_valid) begin
      if (!exp_have) check("unexpected_valid", int'(bus.res_valid), 0);
      else begin
        check("res_detected", int'(bus.res_detected), int'(exp_r.det));
        check("res_code_phase", int'(bus.res_code_phase), exp_r.phase);
        check("res_code_frac", int'(bus.res_code_frac), exp_r.frac);
        check("res_doppler", int'(bus.res_doppler), exp_r.dop);
        check("res_peak", int'(bus.res_peak), exp_r.peak);
        check("res_second", int'(bus.res_second), exp_r.second);
        check("res_sat", int'(bus.res_sat), exp_r.sat);
        check("res_points", int'(bus.res_points), exp_r.points);
      end
    end
  end

  task automatic start_search(input int sat);
    @(posedge clk); #1;
    bus.search_start = 1'b1;
    bus.sat          = 6'(sat);
    cur_sat          = sat;
    @(posedge clk); #1;
    bus.search_start = 1'b0;
    exp_have         = 1'b0;
    pts.delete();
  endtask

  task automatic drive_point(input int phase, input int frac, input int dop, input int count);
    bus.code_phase    = 10'(phase);
    bus.code_nco_frac = 5'(frac);
    bus.doppler_omega = 16'(dop);
    bus.integrator    = 12'(count);
    bus.corr_complete = 1'b1;
  endtask

  task automatic send_point(input int phase, input int frac, input int dop, input int count,
                            input int hold, input bit record);
    pt_t p;
    @(posedge clk); #1;
    drive_point(phase, frac, dop, count);
    p = '{phase: phase, frac: frac, dop: dop, m: (count >= 2048) ? count - 2048 : 2048 - count};
    if (record) pts.push_back(p);
    repeat (hold - 1) @(posedge clk);
    @(posedge clk); #1;
    bus.corr_complete = 1'b0;
  endtask

  task automatic finish_search();
    @(posedge clk); #1;
    bus.search_complete = 1'b1;
    exp_r    = model(pts, cur_sat);
    exp_have = 1'b1;
    @(posedge clk); #1;
    bus.search_complete = 1'b0;
  endtask

  // Last point and search_complete rise in the same cycle.
  task automatic finish_with_point(input int phase, input int frac, input int dop, input int count);
    pt_t p;
    @(posedge clk); #1;
    drive_point(phase, frac, dop, count);
    bus.search_complete = 1'b1;
    p = '{phase: phase, frac: frac, dop: dop, m: (count >= 2048) ? count - 2048 : 2048 - count};
    pts.push_back(p);
    exp_r    = model(pts, cur_sat);
    exp_have = 1'b1;
    @(posedge clk); #1;
    bus.search_complete = 1'b0;
    bus.corr_complete   = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("result_arrives", int'(bus.res_valid), 1);
    check("busy_in_result", int'(bus.busy), 0);
  endtask

  task automatic accept(input int delay);
    repeat (delay) @(posedge clk);
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    exp_have      = 1'b0;
    @(negedge clk);
    check("valid_drops_after_accept", int'(bus.res_valid), 0);
  endtask

  task automatic lit(input string tag, input int det, input int peak, input int sec, input int npts);
    check({tag, "_det"}, int'(bus.res_detected), det);
    check({tag, "_peak"}, int'(bus.res_peak), peak);
    check({tag, "_second"}, int'(bus.res_second), sec);
    check({tag, "_points"}, int'(bus.res_points), npts);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, ph, dp;
    bus.search_start    = 1'b0;
    bus.corr_complete   = 1'b0;
    bus.search_complete = 1'b0;
    bus.code_phase      = '0;
    bus.code_nco_frac   = '0;
    bus.doppler_omega   = '0;
    bus.integrator      = '0;
    bus.sat             = '0;
    bus.res_ready       = 1'b0;

    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(bus.res_valid), 0);
    check("rst_detected", int'(bus.res_detected), 0);
    check("rst_peak", int'(bus.res_peak), 0);
    check("rst_second", int'(bus.res_second), 0);
    check("rst_points", int'(bus.res_points), 0);
    check("rst_phase", int'(bus.res_code_phase), 0);
    check("rst_busy", int'(bus.busy), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Single point, corr_complete held 5 cycles: counted once.
    start_search(5);
    @(negedge clk);
    check("busy_in_search", int'(bus.busy), 1);
    send_point(100, 2, 500, 3000, 5, 1'b1);
    finish_search();
    wait_valid();
    lit("single", 1, 952, 0, 1);
    check("single_phase", int'(bus.res_code_phase), 100);
    accept(3);

    // Adjacent phase excluded; consumer stalls 20 cycles.
    start_search(7);
    send_point(10, 1, -300, 2948, 1, 1'b1);
    send_point(11, 3, -300, 2848, 1, 1'b1);
    send_point(300, 0, -300, 1548, 2, 1'b1);
    finish_search();
    wait_valid();
    lit("excl", 1, 900, 500, 3);
    check("excl_phase", int'(bus.res_code_phase), 10);
    accept(20);

    // Point in IDLE must be ignored.
    send_point(7, 0, 0, 4000, 1, 1'b0);

    // Circular wrap of the exclusion window.
    start_search(9);
    send_point(1022, 4, 0, 2748, 1, 1'b1);
    send_point(0, 0, 0, 1398, 1, 1'b1);
    send_point(5, 2, 0, 2648, 1, 1'b1);
    finish_search();
    wait_valid();
    lit("wrap", 0, 700, 600, 3);
    accept(0);

    // Same phase at another Doppler is not excluded.
    start_search(11);
    send_point(10, 0, 13, 2748, 1, 1'b1);
    send_point(10, 0, 26, 1358, 1, 1'b1);
    finish_search();
    wait_valid();
    lit("dop", 0, 700, 690, 2);
    // New search drops the pending result, then completes with no points.
    start_search(12);
    @(negedge clk);
    check("restart_valid", int'(bus.res_valid), 0);
    check("restart_points", int'(bus.res_points), 0);
    finish_search();
    wait_valid();
    lit("empty", 0, 0, 0, 0);
    accept(1);

    // Point and search_complete rising together.
    start_search(13);
    send_point(50, 0, 0, 2448, 1, 1'b1);
    finish_with_point(200, 1, 0, 3048);
    wait_valid();
    lit("simul", 1, 1000, 400, 2);
    check("simul_phase", int'(bus.res_code_phase), 200);
    accept(0);

    // Reset mid-search: no result afterwards.
    start_search(14);
    send_point(20, 0, 0, 3500, 1, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    pts.delete();
    @(negedge clk);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_valid", int'(bus.res_valid), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 bus.search_complete = 1'b1;
    @(posedge clk); #1 bus.search_complete = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_result", int'(bus.res_valid), 0);
    check("midrst_idle", int'(bus.busy), 0);

    // Random searches, phases clustered to exercise exclusion and wrap.
    for (int s = 0; s < 10; s++) begin
      start_search(int'($urandom_range(0, 63)));
      n = int'($urandom_range(0, 25));
      for (int k = 0; k < n; k++) begin
        r = int'($urandom_range(0, 3));
        case (r)
          0: ph = int'($urandom_range(0, 1022));
          1: ph = int'($urandom_range(0, 4));
          2: ph = int'($urandom_range(1018, 1022));
          default: ph = 500 + int'($urandom_range(0, 4));
        endcase
        r = int'($urandom_range(0, 2));
        dp = (r == 0) ? 0 : ((r == 1) ? 77 : -77);
        send_point(ph, int'($urandom_range(0, 4)), dp, int'($urandom_range(0, 4095)),
                   int'($urandom_range(1, 3)), 1'b1);
      end
      finish_search();
      wait_valid();
      accept(int'($urandom_range(0, 5)));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
